// File: rtl/mem_access.sv
// MEM stage load/store engine: runs one bus access per memory op and feeds mem_wb combinationally.
// Latency: non-memory ops 0 cycles; memory ops stall for ack-delay+2 cycles (3 total with zero-wait ack).
// Backpressure: stallreq holds the pipeline while a request is outstanding; bus_ack is the only completion path besides timeout.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   mem_wd/wreg/wdata/aluop       EX/MEM register outputs
//   mem_mem_addr, mem_reg2        effective address and store data (rt)
//   bus_req/we/addr/sel/wdata     registered data bus request (big-endian lanes, bit3 = [31:24])
//   bus_rdata, bus_ack            read data and 1-cycle completion strobe
//   bus_err                       1-cycle pulse after a timeout abort
//   stallreq                      combinational stall request to ctrl
//   wb_wd/wb_wreg/wb_wdata        combinational write-back fields to mem_wb
// Optional build macro MEM_ALIGN_CHECK_EN: rejects misaligned half/word accesses without touching
// the bus and adds the addr_err_load/addr_err_store outputs.
module mem_access #(
    parameter int unsigned TIMEOUT_CYCLES = 255   // 0 disables the timeout
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_wd,
    input  logic        mem_wreg,
    input  logic [31:0] mem_wdata,
    input  logic [7:0]  mem_aluop,
    input  logic [31:0] mem_mem_addr,
    input  logic [31:0] mem_reg2,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    output logic        bus_err,
    output logic        stallreq,
    output logic [4:0]  wb_wd,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic        addr_err_load,
    output logic        addr_err_store
`endif
);

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_sel_q, bus_sel_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] hold_q, hold_d;

    logic        is_byte, is_half, is_word, is_load, is_store, misalign, start;
    logic [3:0]  req_sel;
    logic [31:0] req_wdata, load_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Decode and request formation
    always_comb begin
        is_byte  = (mem_aluop == EXE_LB_OP) || (mem_aluop == EXE_LBU_OP) || (mem_aluop == EXE_SB_OP);
        is_half  = (mem_aluop == EXE_LH_OP) || (mem_aluop == EXE_LHU_OP) || (mem_aluop == EXE_SH_OP);
        is_word  = (mem_aluop == EXE_LW_OP) || (mem_aluop == EXE_SW_OP);
        is_store = (mem_aluop == EXE_SB_OP) || (mem_aluop == EXE_SH_OP) || (mem_aluop == EXE_SW_OP);
        is_load  = (is_byte || is_half || is_word) && !is_store;
`ifdef MEM_ALIGN_CHECK_EN
        misalign = (is_half && mem_mem_addr[0]) || (is_word && (mem_mem_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        start = (is_byte || is_half || is_word) && !misalign;

        req_sel   = 4'b1111;
        req_wdata = mem_reg2;
        if (is_byte) begin
            req_sel   = 4'b1000 >> mem_mem_addr[1:0];
            req_wdata = {4{mem_reg2[7:0]}};
        end else if (is_half) begin
            req_sel   = mem_mem_addr[1] ? 4'b0011 : 4'b1100;
            req_wdata = {2{mem_reg2[15:0]}};
        end
        if (!is_store) begin
            req_wdata = 32'd0;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_sel_d   = bus_sel_q;
        bus_wdata_d = bus_wdata_q;
        bus_err_d   = 1'b0;
        hold_d      = hold_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bus_req_d   = 1'b1;
                    bus_we_d    = is_store;
                    bus_addr_d  = {mem_mem_addr[31:2], 2'b00};
                    bus_sel_d   = req_sel;
                    bus_wdata_d = req_wdata;
                    cnt_d       = 32'd0;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 32'd1;
                // Ack is checked first so an ack on the final allowed cycle still completes normally.
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    hold_d    = bus_rdata;
                    state_d   = S_DONE;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_CYCLES - 1)) begin
                    bus_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    hold_d    = 32'd0;
                    state_d   = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 32'd0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_sel_q   <= 4'd0;
            bus_wdata_q <= 32'd0;
            bus_err_q   <= 1'b0;
            hold_q      <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_sel_q   <= bus_sel_d;
            bus_wdata_q <= bus_wdata_d;
            bus_err_q   <= bus_err_d;
            hold_q      <= hold_d;
        end
    end

    // Load extraction from the hold register; EX/MEM is frozen during the stall so the
    // op and address inputs still describe the retiring instruction in DONE.
    always_comb begin
        case (mem_mem_addr[1:0])
            2'b00:   ld_byte = hold_q[31:24];
            2'b01:   ld_byte = hold_q[23:16];
            2'b10:   ld_byte = hold_q[15:8];
            default: ld_byte = hold_q[7:0];
        endcase
        ld_half = mem_mem_addr[1] ? hold_q[15:0] : hold_q[31:16];
        case (mem_aluop)
            EXE_LB_OP:  load_data = {{24{ld_byte[7]}}, ld_byte};
            EXE_LBU_OP: load_data = {24'd0, ld_byte};
            EXE_LH_OP:  load_data = {{16{ld_half[15]}}, ld_half};
            EXE_LHU_OP: load_data = {16'd0, ld_half};
            EXE_LW_OP:  load_data = hold_q;
            default:    load_data = mem_wdata;
        endcase
    end

    always_comb begin
        stallreq = !rst && (((state_q == S_IDLE) && start) || (state_q == S_WAIT));
        wb_wd    = rst ? 5'd0  : mem_wd;
        wb_wreg  = rst ? 1'b0  : (mem_wreg && !misalign);
        wb_wdata = rst ? 32'd0 : load_data;
`ifdef MEM_ALIGN_CHECK_EN
        addr_err_load  = !rst && misalign && is_load;
        addr_err_store = !rst && misalign && is_store;
`endif
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_sel   = bus_sel_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

    localparam int T = 4;
    localparam logic [7:0] ADDU = 8'h21;
    localparam logic [7:0] LB = 8'hE0, LH = 8'hE1, LW = 8'hE3, LBU = 8'hE4, LHU = 8'hE5;
    localparam logic [7:0] SB = 8'hE8, SH = 8'hE9, SW = 8'hEB;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata, mem_mem_addr, mem_reg2, bus_rdata;
    logic [7:0]  mem_aluop;
    logic        bus_ack;
    logic        bus_req, bus_we, bus_err, stallreq, wb_wreg;
    logic [31:0] bus_addr, bus_wdata, wb_wdata;
    logic [3:0]  bus_sel;
    logic [4:0]  wb_wd;
`ifdef MEM_ALIGN_CHECK_EN
    logic        addr_err_load, addr_err_store;
`endif

    mem_access #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_aluop(mem_aluop),
        .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
        .bus_wdata(bus_wdata), .bus_err(bus_err), .stallreq(stallreq),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata)
`ifdef MEM_ALIGN_CHECK_EN
        , .addr_err_load(addr_err_load), .addr_err_store(addr_err_store)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Observations from the most recent run_op
    int          o_stall, o_req, o_err;
    logic        o_done, o_we, o_wreg;
    logic [31:0] o_wdata, o_baddr, o_bwdata;
    logic [3:0]  o_sel;
    logic [4:0]  o_wd;

    // Entered just after a falling edge; drives one instruction, acts as the bus slave
    // (ack on the (dly+1)-th cycle of bus_req high) and leaves after the retiring cycle.
    task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rt,
                          input logic [31:0] wd, input logic [31:0] rdata, input int dly);
        int rq;
        rq = 0;
        mem_aluop = op; mem_mem_addr = addr; mem_reg2 = rt; mem_wdata = wd;
        mem_wd = 5'd7; mem_wreg = !(op == SB || op == SH || op == SW);
        bus_rdata = rdata; bus_ack = 1'b0;
        o_stall = 0; o_req = 0; o_err = 0; o_done = 1'b0;
        o_we = 1'b0; o_baddr = '0; o_sel = '0; o_bwdata = '0;
        o_wdata = '0; o_wreg = 1'b0; o_wd = '0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (bus_req) begin
                if (rq == 0) begin
                    o_we = bus_we; o_baddr = bus_addr; o_sel = bus_sel; o_bwdata = bus_wdata;
                end
                bus_ack = (rq == dly);
                rq++;
            end
            if (bus_err) o_err++;
            if (stallreq) o_stall++;
            else begin
                o_done = 1'b1; o_wdata = wb_wdata; o_wreg = wb_wreg; o_wd = wb_wd;
            end
            @(negedge clk);
            bus_ack = 1'b0;
            if (o_done) break;
        end
        o_req = rq;
    endtask

    // Reference: expected stall length, result and bus request from the access rules.
    task automatic model(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rt,
                         input logic [31:0] wd, input logic [31:0] rdata, input int dly,
                         output logic [31:0] e_wdata, output logic e_we, output logic [31:0] e_baddr,
                         output logic [3:0] e_sel, output logic [31:0] e_bwdata,
                         output int e_stall, output int e_err);
        int unsigned a, v, waits;
        logic mem, tmo;
        a   = addr % 4;
        mem = (op == LB || op == LBU || op == LH || op == LHU || op == LW ||
               op == SB || op == SH || op == SW);
        tmo = mem && (dly + 1 > T);
        waits = (dly + 1 > T) ? T : dly + 1;
        e_stall  = mem ? 1 + waits : 0;
        e_err    = tmo ? 1 : 0;
        e_we     = (op == SB || op == SH || op == SW);
        e_baddr  = addr - a;
        v = tmo ? 0 : rdata;
        e_wdata = wd;
        e_sel = 4'hF;
        e_bwdata = rt;
        if (op == LB || op == LBU || op == SB) begin
            e_sel = 4'(1 << (3 - a));
            e_bwdata = (rt % 256) * 32'h01010101;
            e_wdata = (v >> (8 * (3 - a))) % 256;
            if (op == LB && e_wdata > 127) e_wdata = e_wdata + 32'hFFFFFF00;
        end else if (op == LH || op == LHU || op == SH) begin
            e_sel = (a >= 2) ? 4'b0011 : 4'b1100;
            e_bwdata = (rt % 65536) * 32'h00010001;
            e_wdata = (v >> ((a >= 2) ? 0 : 16)) % 65536;
            if (op == LH && e_wdata > 32767) e_wdata = e_wdata + 32'hFFFF0000;
        end else if (op == LW) begin
            e_wdata = v;
        end
    endtask

    task automatic check_op(input string nm, input logic [7:0] op, input int dly,
                            input logic [31:0] e_wdata, input logic e_we, input logic [31:0] e_baddr,
                            input logic [3:0] e_sel, input logic [31:0] e_bwdata,
                            input int e_stall, input int e_err);
        logic st, mem;
        int   waits;
        st  = (op == SB || op == SH || op == SW);
        mem = e_stall != 0;
        waits = (dly + 1 > T) ? T : dly + 1;
        chk({nm, " retired"}, o_done, 1'b1);
        chk({nm, " stall_cycles"}, o_stall, e_stall);
        chk({nm, " req_cycles"}, o_req, mem ? waits : 0);
        chk({nm, " bus_err_pulses"}, o_err, e_err);
        chk({nm, " wb_wreg"}, o_wreg, !st);
        chk({nm, " wb_wd"}, o_wd, 5'd7);
        if (!st) chk({nm, " wb_wdata"}, o_wdata, e_wdata);
        if (mem) begin
            chk({nm, " bus_we"}, o_we, e_we);
            chk({nm, " bus_addr"}, o_baddr, e_baddr);
            chk({nm, " bus_sel"}, o_sel, e_sel);
            if (st) chk({nm, " bus_wdata"}, o_bwdata, e_bwdata);
        end
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr, rt, wd, rdata;
        int          dly;
        logic [31:0] e_wdata;
        logic        e_we;
        logic [31:0] e_baddr;
        logic [3:0]  e_sel;
        logic [31:0] e_bwdata;
        int          e_stall, e_err;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [31:0] e_wdata, e_baddr, e_bwdata, addr, rt, rd, wd;
        logic        e_we;
        logic [3:0]  e_sel;
        logic [7:0]  op;
        logic [7:0]  ops[9];
        int          e_stall, e_err, dly;

        vecs[0]  = '{ADDU, 32'h0,   32'h0,        32'h1234, 32'h0,        0, 32'h1234,     1'b0, 32'h0,   4'h0,    32'h0,        0, 0};
        vecs[1]  = '{LB,   32'h103, 32'h0,        32'h0,    32'h000000F0, 2, 32'hFFFFFFF0, 1'b0, 32'h100, 4'b0001, 32'h0,        4, 0};
        vecs[2]  = '{SH,   32'h202, 32'hABCD1234, 32'hDEAD, 32'h0,        0, 32'h0,        1'b1, 32'h200, 4'b0011, 32'h12341234, 2, 0};
        vecs[3]  = '{LW,   32'h300, 32'h0,        32'h0,    32'h11223344, 9, 32'h0,        1'b0, 32'h300, 4'b1111, 32'h0,        5, 1};
        vecs[4]  = '{LW,   32'h101, 32'h0,        32'h0,    32'hCAFEBABE, 0, 32'hCAFEBABE, 1'b0, 32'h100, 4'b1111, 32'h0,        2, 0};
        vecs[5]  = '{LBU,  32'h101, 32'h0,        32'h0,    32'h12F45678, 1, 32'h000000F4, 1'b0, 32'h100, 4'b0100, 32'h0,        3, 0};
        vecs[6]  = '{LH,   32'h402, 32'h0,        32'h0,    32'h12348001, 3, 32'hFFFF8001, 1'b0, 32'h400, 4'b0011, 32'h0,        5, 0};
        vecs[7]  = '{LHU,  32'h500, 32'h0,        32'h0,    32'h87654321, 0, 32'h00008765, 1'b0, 32'h500, 4'b1100, 32'h0,        2, 0};
        vecs[8]  = '{SB,   32'h601, 32'h000000A5, 32'h0,    32'h0,        1, 32'h0,        1'b1, 32'h600, 4'b0100, 32'hA5A5A5A5, 3, 0};
        vecs[9]  = '{SW,   32'h703, 32'h89ABCDEF, 32'h0,    32'h0,        0, 32'h0,        1'b1, 32'h700, 4'b1111, 32'h89ABCDEF, 2, 0};
        vecs[10] = '{LB,   32'h100, 32'h0,        32'h0,    32'h7F000000, 0, 32'h0000007F, 1'b0, 32'h100, 4'b1000, 32'h0,        2, 0};

        // Reset with a memory op presented: everything must read zero.
        rst = 1'b1; bus_ack = 1'b0; bus_rdata = 32'hFFFFFFFF;
        mem_aluop = LW; mem_mem_addr = 32'h123; mem_reg2 = 32'h55; mem_wdata = 32'h99;
        mem_wd = 5'd9; mem_wreg = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst stallreq", stallreq, 1'b0);
        chk("rst wb_wreg", wb_wreg, 1'b0);
        chk("rst wb_wdata", wb_wdata, 32'h0);
        chk("rst wb_wd", wb_wd, 5'd0);
        chk("rst bus_req", bus_req, 1'b0);
        chk("rst bus_we", bus_we, 1'b0);
        chk("rst bus_addr", bus_addr, 32'h0);
        chk("rst bus_sel", bus_sel, 4'h0);
        chk("rst bus_wdata", bus_wdata, 32'h0);
        chk("rst bus_err", bus_err, 1'b0);
        mem_aluop = ADDU;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].op, vecs[i].addr, vecs[i].rt, vecs[i].wd, vecs[i].rdata, vecs[i].dly);
            check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].dly, vecs[i].e_wdata, vecs[i].e_we,
                     vecs[i].e_baddr, vecs[i].e_sel, vecs[i].e_bwdata, vecs[i].e_stall, vecs[i].e_err);
        end

        // Reset while waiting for ack: aborts without bus_err.
        mem_aluop = LW; mem_mem_addr = 32'h800; mem_wdata = 32'h0; mem_wreg = 1'b1; bus_ack = 1'b0;
        @(negedge clk); #1;
        chk("rstwait req_up", bus_req, 1'b1);
        rst = 1'b1; mem_aluop = ADDU; mem_wdata = 32'h55;
        #1;
        chk("rstwait stall_in_rst", stallreq, 1'b0);
        @(negedge clk);
        rst = 1'b0; #1;
        chk("rstwait bus_req", bus_req, 1'b0);
        chk("rstwait stallreq", stallreq, 1'b0);
        chk("rstwait bus_err", bus_err, 1'b0);
        chk("rstwait wb_wdata", wb_wdata, 32'h55);
        @(negedge clk); #1;
        chk("rstwait bus_err_late", bus_err, 1'b0);
        @(negedge clk);
        run_op(LW, 32'h804, 32'h0, 32'h0, 32'h5A5AA5A5, 1);
        check_op("after_rst", LW, 1, 32'h5A5AA5A5, 1'b0, 32'h804, 4'hF, 32'h0, 3, 0);

        // Randomized back-to-back traffic against the reference.
        ops = '{ADDU, LB, LBU, LH, LHU, LW, SB, SH, SW};
        for (int i = 0; i < 150; i++) begin
            op   = ops[$urandom_range(0, 8)];
            addr = $urandom; rt = $urandom; rd = $urandom; wd = $urandom;
            dly  = $urandom_range(0, 6);
            model(op, addr, rt, wd, rd, dly, e_wdata, e_we, e_baddr, e_sel, e_bwdata, e_stall, e_err);
            run_op(op, addr, rt, wd, rd, dly);
            check_op($sformatf("rnd%0d", i), op, dly, e_wdata, e_we, e_baddr, e_sel, e_bwdata, e_stall, e_err);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
